jk_bank_sequencer: RTL
======================

# jk_bank_sequencer

Controller for a WIDTH-bit bank of JK flip-flop state bits. It accepts per-bit set, reset, toggle and hold commands from two requesters over valid/ready handshakes and arbitrates between them. Each accepted command is applied to the bank for a programmed number of consecutive cycles. The bank state is held inside the block, uses JK next-state semantics, and is exported on `q` for the downstream datapath.

## Interface
- `WIDTH`, default 8: number of JK state bits in the bank.
- `LEN_W`, default 4: width of the repeat-length field.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; synchronous, active-high.
- `req0_valid`  input  1  requester 0 holds a command.
- `req0_ready`  output  1  requester 0 command accepted this cycle.
- `req0_op`  input  2  operation code: 00 hold, 01 reset, 10 set, 11 toggle.
- `req0_mask`  input  WIDTH  selects the bits the operation applies to.
- `req0_len`  input  LEN_W  number of applications minus 1.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_mask`, `req1_len`: same as requester 0, for requester 1.
- `q`  output  WIDTH  bank state.
- `busy`  output  1  high while the block is in EXEC or DONE.
- `done`  output  1  one-cycle pulse when a command completes.
- `done_id`  output  1  requester that owns the completing command; valid only while `done`=1.

## Operation
- **Per-bit JK update.** Each bit follows `q_next = (j & ~q) | (~k & q)`.
  - Bits with mask=1 take j/k from the latched op: hold → j=0,k=0; reset → j=0,k=1; set → j=1,k=0; toggle → j=1,k=1.
  - Bits with mask=0 get j=k=0 and are therefore held.
- **State machine:** three states, IDLE, EXEC, DONE.
- **IDLE**
  - The grant is combinational from `req*_valid` and the arbitration state.
  - The granted requester's `ready` is 1 in the same cycle. A transfer occurs when `valid` and `ready` are both 1.
  - On transfer: latch op, mask, len and the requester id; load the counter with len; go to EXEC.
  - The bank holds while in IDLE.
- **EXEC**
  - Apply the latched op on every cycle.
  - If counter = 0, go to DONE. Otherwise decrement the counter.
  - Total applications = len + 1. len = 0 gives exactly one application; len = 2^LEN_W − 1 gives 2^LEN_W applications.
- **DONE**
  - Assert `done`=1 and drive `done_id`.
  - The bank holds. Go to IDLE on the next cycle.
- Both `req*_ready` outputs are 0 in EXEC and DONE. Requesters hold `valid` and their fields stable until `ready`.
- The command fields are sampled only on the transfer cycle. Changes during EXEC have no effect.
- Toggle wraps naturally: an odd number of applications inverts the masked bits, an even number restores them.

## Timing
- **Command sequence.** For a command accepted on edge T:
  - The first `q` update is visible after edge T+1.
  - The last `q` update is visible after edge T+1+len.
  - `done`=1 during the cycle after edge T+2+len.
  - The earliest next acceptance is on edge T+3+len.
- **Reset.** `rst`=1 on an edge forces the following, from any state, including mid-EXEC:
  - `q`=0, state = IDLE, counter = 0, `done`=0, `done_id`=0, `busy`=0.
  - The arbitration pointer resets to "last granted = 1", so requester 0 wins the first tie.
  - `req*_ready` is forced to 0 while `rst` is high.
  - An aborted command produces no `done`.
- **Arbitration.** If only one requester is valid, it is granted. Tie-breaking with both valid is set by the configuration below.

## Configuration
- Macro: `JK_BANK_SEQ_RR_EN`.
- **Defined:** round-robin arbitration.
  - When both requesters are valid, grant the one not granted last.
  - The pointer updates only on a transfer.
- **Undefined:** fixed priority. Requester 0 always wins a tie, and the pointer logic is not built.

## Test plan
- **Single set:** after reset, requester 0 sends set, mask 0x0F, len 0 → `req0_ready`=1 for 1 cycle; `q`=0x0F one edge later; `done`=1 with `done_id`=0 one cycle after that; `busy` high for 2 cycles.
- **Repeated toggle:** from `q`=0x00, send toggle, mask 0x01, len 4 → `q` bit 0 reads 1,0,1,0,1 on successive edges; final `q`=0x01; `done` asserted 6 cycles after the transfer edge.
- **Simultaneous requests:** both requesters hold set commands (req0 mask 0x01, req1 mask 0x80), re-presenting after each acceptance.
  - With the macro: grants go 0 then 1, final `q`=0x81.
  - Without the macro: grants go 0, then 0 again while req0 stays valid, and req1 waits.
- **Reset mid-EXEC:** toggle mask 0xFF, len 15; assert `rst` at the 5th application → `q`=0x00, `busy`=0 and no `done` on the next cycle; a new request is accepted the cycle after `rst` deasserts.
- **Hold and masking:** with `q`=0xA5, send hold, mask 0xFF, len 3 → `q` stays 0xA5 throughout; `done` pulses once. Then send reset, mask 0xF0, len 0 → `q`=0x05.
- **Stability while busy:** during EXEC, hold `req1_valid` and change its fields → `req1_ready` stays 0 until IDLE; the values latched at acceptance are the ones present on the acceptance cycle.

Source files
------------

// File: rtl/jk_bank_sequencer.sv
// Two-requester command sequencer driving a bank of JK state bits.
// Optional JK_BANK_SEQ_RR_EN selects round-robin tie-breaking; otherwise requester 0 has fixed priority.
module jk_bank_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_mask,
  input  logic [LEN_W-1:0] req0_len,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_mask,
  input  logic [LEN_W-1:0] req1_len,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             done_id
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   mask_r;
  logic [LEN_W-1:0]   cnt;
  logic               id_r;
  logic               grant_id;
  logic               xfer;
  logic [1:0]         sel_op;
  logic [WIDTH-1:0]   sel_mask;
  logic [LEN_W-1:0]   sel_len;
  logic [WIDTH-1:0]   j;
  logic [WIDTH-1:0]   k;
  logic [WIDTH-1:0]   q_next;

`ifdef JK_BANK_SEQ_RR_EN
  logic last_grant;

  // Round-robin pointer: remembers the requester of the last transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (xfer) begin
      last_grant <= grant_id;
    end
  end

  always_comb begin
    grant_id = ~req0_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end
  end
`else
  always_comb begin
    grant_id = ~req0_valid;
  end
`endif

  always_comb begin
    sel_op   = grant_id ? req1_op   : req0_op;
    sel_mask = grant_id ? req1_mask : req0_mask;
    sel_len  = grant_id ? req1_len  : req0_len;
  end

  // JK update: op[1] drives j, op[0] drives k, unmasked bits see j=k=0.
  always_comb begin
    j      = mask_r & {WIDTH{op_r[1]}};
    k      = mask_r & {WIDTH{op_r[0]}};
    q_next = (j & ~q) | (~k & q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          xfer       = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // done is registered off the DONE state, so the pulse trails the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      op_r    <= 2'b00;
      mask_r  <= '0;
      cnt     <= '0;
      id_r    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
    end else begin
      busy    <= (state_next != IDLE);
      done    <= (state == DONE);
      done_id <= (state == DONE) ? id_r : 1'b0;
      if (xfer) begin
        op_r   <= sel_op;
        mask_r <= sel_mask;
        cnt    <= sel_len;
        id_r   <= grant_id;
      end
      if (state == EXEC) begin
        q <= q_next;
        if (cnt != '0) begin
          cnt <= cnt - LEN_W'(1);
        end
      end
    end
  end

endmodule
